// File: rtl/wb_mem_arbiter_if.sv
// Bus bundle between the core's d$/i$ request ports, the store buffer/arbiter and the RAM.
//   slave  : view used by wb_mem_arbiter (takes core requests and RAM responses, drives the rest)
//   master : view used by whatever drives the core and RAM sides (e.g. a testbench)
// Signal groups: d$ load request/response, d$ store request, i$ fetch, RAM port, buffer status.
interface wb_mem_arbiter_if #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned LQ_IDX_W = 3
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  // d$ load
  logic                dread_req_valid;
  logic [LQ_IDX_W-1:0] dread_req_lq_index;
  logic [ADDR_W-1:0]   dread_req_addr;
  logic                dread_req_blocked;
  logic                dread_resp_valid;
  logic [LQ_IDX_W-1:0] dread_resp_lq_index;
  logic [DATA_W-1:0]   dread_resp_data;
  // d$ store
  logic                dwrite_req_valid;
  logic [ADDR_W-1:0]   dwrite_req_addr;
  logic [DATA_W-1:0]   dwrite_req_data;
  logic                dwrite_req_blocked;
  // i$ fetch
  logic                iread_req;
  logic [31:0]         iread_addr;
  logic                iread_hit;
  logic [DATA_W-1:0]   iread_data;
  // RAM port
  logic                mem_ren;
  logic                mem_wen;
  logic [31:0]         mem_addr;
  logic [DATA_W-1:0]   mem_store;
  logic [DATA_W-1:0]   mem_load;
  logic                mem_ready;
  // buffer status
  logic                wb_empty;
  logic [CNT_W-1:0]    wb_count;

  modport slave (
    input  dread_req_valid, dread_req_lq_index, dread_req_addr,
    output dread_req_blocked, dread_resp_valid, dread_resp_lq_index, dread_resp_data,
    input  dwrite_req_valid, dwrite_req_addr, dwrite_req_data,
    output dwrite_req_blocked,
    input  iread_req, iread_addr,
    output iread_hit, iread_data,
    output mem_ren, mem_wen, mem_addr, mem_store,
    input  mem_load, mem_ready,
    output wb_empty, wb_count
  );

  modport master (
    output dread_req_valid, dread_req_lq_index, dread_req_addr,
    input  dread_req_blocked, dread_resp_valid, dread_resp_lq_index, dread_resp_data,
    output dwrite_req_valid, dwrite_req_addr, dwrite_req_data,
    input  dwrite_req_blocked,
    output iread_req, iread_addr,
    input  iread_hit, iread_data,
    input  mem_ren, mem_wen, mem_addr, mem_store,
    output mem_load, mem_ready,
    input  wb_empty, wb_count
  );
endinterface

// File: rtl/wb_mem_arbiter.sv
// Store buffer and single-port RAM arbiter for one core.
// d$ stores are queued in a DEPTH-entry FIFO and drained to RAM; d$ loads are forwarded from the
// youngest matching buffered store or read from RAM; i$ fetches get the RAM when nothing else does.
// Ports: CLK, nRST (async active-low), bus (wb_mem_arbiter_if.slave: d$ load/store, i$ fetch,
// RAM port, wb_empty/wb_count).
// Optional feature: define WB_COALESCE_EN to merge a store into the youngest entry when the
// address matches (accepted even when the buffer is full).
module wb_mem_arbiter #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned LQ_IDX_W = 3
) (
  input logic             CLK,
  input logic             nRST,
  wb_mem_arbiter_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  typedef enum logic [1:0] {GntNone, GntDrain, GntLoad, GntFetch} gnt_e;
  typedef enum logic {StIdle, StFetchWait} state_e;

  logic [DEPTH-1:0]    valid_q;
  logic [ADDR_W-1:0]   addr_q [DEPTH];
  logic [DATA_W-1:0]   data_q [DEPTH];
  logic [PTR_W-1:0]    head_q, tail_q, count;
  logic [IDX_W-1:0]    head_idx, tail_idx, fwd_idx;
  logic                full, empty;
  logic                fwd_hit;
  logic [DATA_W-1:0]   fwd_data;
  logic                drain_done, load_served, enq, coalesce;
  state_e              state_q, state_d;
  gnt_e                gnt;
  logic                resp_valid_q;
  logic [LQ_IDX_W-1:0] resp_lq_q;
  logic [DATA_W-1:0]   resp_data_q;

  assign head_idx = head_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];
  assign count    = tail_q - head_q;
  assign empty    = (head_q == tail_q);
  assign full     = (head_idx == tail_idx) && (head_q[PTR_W-1] != tail_q[PTR_W-1]);

  // Walk oldest to youngest so the last match (closest to tail) wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = head_idx + IDX_W'(i);
      if ((PTR_W'(i) < count) && valid_q[fwd_idx] && (addr_q[fwd_idx] == bus.dread_req_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end

  // Arbitration and next state. A fetch left waiting on RAM keeps its grant against a plain
  // drain; only a full buffer or a new d$ load may take the port from it.
  always_comb begin
    gnt = GntNone;
    if (full) begin
      gnt = GntDrain;
    end else if (bus.dread_req_valid && !fwd_hit) begin
      gnt = GntLoad;
    end else if ((state_q == StFetchWait) && bus.iread_req) begin
      gnt = GntFetch;
    end else if (!empty) begin
      gnt = GntDrain;
    end else if (bus.iread_req) begin
      gnt = GntFetch;
    end
    state_d = ((gnt == GntFetch) && !bus.mem_ready) ? StFetchWait : StIdle;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // RAM request outputs
  always_comb begin
    bus.mem_ren  = 1'b0;
    bus.mem_wen  = 1'b0;
    bus.mem_addr = '0;
    unique case (gnt)
      GntDrain: begin
        bus.mem_wen  = 1'b1;
        bus.mem_addr = {{(32-ADDR_W-2){1'b0}}, addr_q[head_idx], 2'b00};
      end
      GntLoad: begin
        bus.mem_ren  = 1'b1;
        bus.mem_addr = {{(32-ADDR_W-2){1'b0}}, bus.dread_req_addr, 2'b00};
      end
      GntFetch: begin
        bus.mem_ren  = 1'b1;
        bus.mem_addr = bus.iread_addr;
      end
      default: ;
    endcase
  end

  assign bus.mem_store  = data_q[head_idx];
  assign bus.iread_hit  = (gnt == GntFetch) && bus.mem_ready;
  assign bus.iread_data = bus.mem_load;

  assign drain_done  = (gnt == GntDrain) && bus.mem_ready;
  assign load_served = bus.dread_req_valid && (fwd_hit || ((gnt == GntLoad) && bus.mem_ready));
  assign bus.dread_req_blocked = bus.dread_req_valid && !load_served;

`ifdef WB_COALESCE_EN
  logic [IDX_W-1:0] young_idx;
  assign young_idx = tail_idx - 1'b1;
  // Never merge into the head entry in the cycle its drain completes: that data is already gone.
  assign coalesce = bus.dwrite_req_valid && !empty && valid_q[young_idx] &&
                    (addr_q[young_idx] == bus.dwrite_req_addr) &&
                    !((young_idx == head_idx) && drain_done);
`else
  assign coalesce = 1'b0;
`endif

  assign bus.dwrite_req_blocked = full && !coalesce;
  assign enq = bus.dwrite_req_valid && !full && !coalesce;

  // Enqueue and dequeue never share an index: that would need the buffer to be full, and a full
  // buffer accepts no allocating store.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (enq) begin
        valid_q[tail_idx] <= 1'b1;
        addr_q[tail_idx]  <= bus.dwrite_req_addr;
        data_q[tail_idx]  <= bus.dwrite_req_data;
        tail_q            <= tail_q + 1'b1;
      end
`ifdef WB_COALESCE_EN
      if (coalesce) begin
        data_q[young_idx] <= bus.dwrite_req_data;
      end
`endif
      if (drain_done) begin
        valid_q[head_idx] <= 1'b0;
        head_q            <= head_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      resp_valid_q <= 1'b0;
      resp_lq_q    <= '0;
      resp_data_q  <= '0;
    end else begin
      resp_valid_q <= load_served;
      if (load_served) begin
        resp_lq_q   <= bus.dread_req_lq_index;
        resp_data_q <= fwd_hit ? fwd_data : bus.mem_load;
      end
    end
  end

  assign bus.dread_resp_valid    = resp_valid_q;
  assign bus.dread_resp_lq_index = resp_lq_q;
  assign bus.dread_resp_data     = resp_data_q;
  assign bus.wb_empty            = empty;
  assign bus.wb_count            = count;
endmodule
